alu_divider: RTL and testbench

Multi-cycle RV64M division unit alongside the combinational ALU shifter. Performs the inverse of the shifter's left-shift-as-multiply: radix-2 restoring shift-subtract division for DIV/DIVU/REM/REMU and their 32-bit W forms. The execute stage hands it operands through a valid/ready handshake and stalls until the result returns on a second valid/ready handshake.

---
 rtl/div_pkg.sv | 25 ++
 rtl/div_step.sv | 31 +++
 rtl/alu_divider.sv | 165 ++++++++++++++++
 tb/tb_alu_divider.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the RV64M divider.
// Contents: op-bit positions inside div_control, the FSM state enum,
// the datapath widths, and a 32->64 sign-extension helper.
package div_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned WLEN = 32;

  // Bit positions in div_control
  localparam int unsigned OP_W   = 2;  // 32-bit W form
  localparam int unsigned OP_REM = 1;  // return remainder instead of quotient
  localparam int unsigned OP_UNS = 0;  // unsigned operation

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } div_state_t;

  function automatic logic [XLEN-1:0] sext32(input logic [WLEN-1:0] v);
    return {{(XLEN-WLEN){v[WLEN-1]}}, v};
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// Ports:
//   rem_in       - current partial remainder
//   dividend_bit - next dividend bit, MSB first
//   divisor      - divisor magnitude
//   rem_out      - updated partial remainder
//   quot_bit     - quotient bit produced by this iteration
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] rem_in,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            quot_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Shifted remainder needs XLEN+1 bits; an explicit compare (rather than
  // the subtract borrow) keeps divide-by-zero yielding all-ones quotient
  // bits even once the remainder's top bit is set.
  always_comb begin
    shifted  = {rem_in, dividend_bit};
    diff     = shifted - {1'b0, divisor};
    quot_bit = (shifted >= {1'b0, divisor});
    rem_out  = quot_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle RV64M divider: DIV/DIVU/REM/REMU and their W forms using
// radix-2 restoring shift-subtract, one quotient bit per cycle.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_valid/in_ready - operand handshake (src1 dividend, src2 divisor,
//                       div_control = {W, REM, UNSIGNED})
//   flush             - abort any operation, back to IDLE next cycle
//   out_valid/out_ready - result handshake, div_out holds the result
// Build option: define DIV_SPECIAL_FAST_EN to resolve divide-by-zero and
// signed overflow at accept and jump straight to DONE.
module alu_divider
  import div_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [2:0]      div_control,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] div_out
);

  div_state_t state, state_next;

  logic            accept;
  logic            is_w, is_rem, is_uns;
  logic [XLEN-1:0] op1, op2, mag1, mag2;
  logic            s1, s2;
  logic            fast_take;
  logic [XLEN-1:0] fast_res;

  logic [XLEN-1:0] dividend_q, divisor_q, rem_q, quot_q;
  logic [6:0]      cnt_q, cnt_last;
  logic            is_w_q, is_rem_q, q_neg_q, r_neg_q;

  logic [XLEN-1:0] rem_nxt;
  logic            qbit;
  logic [XLEN-1:0] q_fix, r_fix, sel_res, fix_res;

  // Operand preparation for the op being offered
  always_comb begin
    is_w   = div_control[OP_W];
    is_rem = div_control[OP_REM];
    is_uns = div_control[OP_UNS];
    if (is_w) begin
      op1 = is_uns ? {{(XLEN-WLEN){1'b0}}, src1[WLEN-1:0]} : sext32(src1[WLEN-1:0]);
      op2 = is_uns ? {{(XLEN-WLEN){1'b0}}, src2[WLEN-1:0]} : sext32(src2[WLEN-1:0]);
    end else begin
      op1 = src1;
      op2 = src2;
    end
    s1   = !is_uns && op1[XLEN-1];
    s2   = !is_uns && op2[XLEN-1];
    mag1 = s1 ? (~op1 + 1'b1) : op1;
    mag2 = s2 ? (~op2 + 1'b1) : op2;
  end

`ifdef DIV_SPECIAL_FAST_EN
  logic            div_zero, sgn_ovf;
  logic [XLEN-1:0] op1_fmt;

  always_comb begin
    div_zero  = (op2 == '0);
    sgn_ovf   = !is_uns && (op2 == '1) &&
                (op1 == (is_w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    op1_fmt   = is_w ? sext32(op1[WLEN-1:0]) : op1;
    fast_take = div_zero || sgn_ovf;
    if (div_zero) fast_res = is_rem ? op1_fmt : '1;
    else          fast_res = is_rem ? '0 : op1_fmt;
  end
`else
  always_comb begin
    fast_take = 1'b0;
    fast_res  = '0;
  end
`endif

  div_step u_step (
    .rem_in       (rem_q),
    .dividend_bit (dividend_q[XLEN-1]),
    .divisor      (divisor_q),
    .rem_out      (rem_nxt),
    .quot_bit     (qbit)
  );

  assign cnt_last = is_w_q ? 7'(WLEN - 1) : 7'(XLEN - 1);
  assign accept   = in_valid && in_ready && !flush;

  // Sign fix-up and result formatting
  always_comb begin
    q_fix   = q_neg_q ? (~quot_q + 1'b1) : quot_q;
    r_fix   = r_neg_q ? (~rem_q + 1'b1) : rem_q;
    sel_res = is_rem_q ? r_fix : q_fix;
    fix_res = is_w_q ? sext32(sel_res[WLEN-1:0]) : sel_res;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_next = fast_take ? DONE : BUSY;
        BUSY: if (cnt_q == cnt_last) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      is_w_q     <= 1'b0;
      is_rem_q   <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_out    <= '0;
    end else if (accept) begin
      // W ops pre-shift so the 32 meaningful dividend bits come out first
      dividend_q <= is_w ? {mag1[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : mag1;
      divisor_q  <= mag2;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      is_w_q     <= is_w;
      is_rem_q   <= is_rem;
      // No quotient negation on divide-by-zero so the all-ones result stands
      q_neg_q    <= (s1 ^ s2) && (op2 != '0);
      r_neg_q    <= s1;
      if (fast_take) div_out <= fast_res;
    end else if (!flush && state == BUSY) begin
      dividend_q <= {dividend_q[XLEN-2:0], 1'b0};
      rem_q      <= rem_nxt;
      quot_q     <= {quot_q[XLEN-2:0], qbit};
      cnt_q      <= cnt_q + 7'd1;
    end else if (!flush && state == FIX) begin
      div_out    <= fix_res;
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
module tb_alu_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src1, src2;
  logic [2:0]  div_control;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] div_out;

  int checks = 0;
  int errors = 0;

`ifdef DIV_SPECIAL_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int LAT64 = 66;
  localparam int LAT32 = 34;
  localparam int SP64  = FAST ? 1 : LAT64;
  localparam int SP32  = FAST ? 1 : LAT32;

  localparam logic [2:0] C_DIV   = 3'b000;
  localparam logic [2:0] C_DIVU  = 3'b001;
  localparam logic [2:0] C_REM   = 3'b010;
  localparam logic [2:0] C_REMU  = 3'b011;
  localparam logic [2:0] C_DIVW  = 3'b100;
  localparam logic [2:0] C_DIVUW = 3'b101;
  localparam logic [2:0] C_REMW  = 3'b110;
  localparam logic [2:0] C_REMUW = 3'b111;

  alu_divider dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .src1        (src1),
    .src2        (src2),
    .div_control (div_control),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .div_out     (div_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency, optionally stall the output, then retire it
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] ctrl, input logic [63:0] exp,
                        input int exp_lat, input int hold);
    int cyc;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; src1 = a; src2 = b; div_control = ctrl;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, ".result"}, div_out, exp);
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk({tag, ".held_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".held_result"}, div_out, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".retired"}, 64'(out_valid), 64'd0);
    chk({tag, ".idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int ov_seen;
    rst = 1'b1; in_valid = 1'b0; src1 = '0; src2 = '0; div_control = '0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.in_ready", 64'(in_ready), 64'd0);
    chk("reset.out_valid", 64'(out_valid), 64'd0);
    chk("reset.div_out", div_out, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset.in_ready", 64'(in_ready), 64'd1);

    run_op("divu_100_7", 64'd100, 64'd7, C_DIVU, 64'd14, LAT64, 5);
    run_op("remu_100_7", 64'd100, 64'd7, C_REMU, 64'd2, LAT64, 0);
    run_op("div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, C_DIV, 64'hFFFF_FFFF_FFFF_FFFD, LAT64, 0);
    run_op("rem_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, C_REM, 64'hFFFF_FFFF_FFFF_FFFF, LAT64, 0);
    run_op("divu_by0", 64'h1234, 64'd0, C_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, SP64, 0);
    run_op("remu_by0", 64'h1234, 64'd0, C_REMU, 64'h1234, SP64, 0);
    run_op("div_neg_by0", 64'hFFFF_FFFF_FFFF_FFF7, 64'd0, C_DIV, 64'hFFFF_FFFF_FFFF_FFFF, SP64, 0);
    run_op("rem_neg_by0", 64'hFFFF_FFFF_FFFF_FFF7, 64'd0, C_REM, 64'hFFFF_FFFF_FFFF_FFF7, SP64, 0);
    run_op("div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, C_DIV, 64'h8000_0000_0000_0000, SP64, 0);
    run_op("rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, C_REM, 64'd0, SP64, 0);
    run_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, C_DIVW, 64'hFFFF_FFFF_8000_0000, SP32, 0);
    run_op("remw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, C_REMW, 64'd0, SP32, 0);
    run_op("divuw_max_1", 64'h0000_0000_FFFF_FFFF, 64'd1, C_DIVUW, 64'hFFFF_FFFF_FFFF_FFFF, LAT32, 0);
    run_op("remuw_hi_ignored", 64'h0000_0001_0000_0007, 64'hABCD_0000_0000_0005, C_REMUW, 64'd2, LAT32, 0);
    run_op("divw_m20_3", 64'h1234_5678_FFFF_FFEC, 64'd3, C_DIVW, 64'hFFFF_FFFF_FFFF_FFFA, LAT32, 0);
    run_op("remw_m20_3", 64'h1234_5678_FFFF_FFEC, 64'd3, C_REMW, 64'hFFFF_FFFF_FFFF_FFFE, LAT32, 0);

    // Accept coinciding with flush is dropped
    in_valid = 1'b1; flush = 1'b1; src1 = 64'd50; src2 = 64'd5; div_control = C_DIVU;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept.in_ready", 64'(in_ready), 64'd1);
    ov_seen = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    chk("flush_accept.no_valid", 64'(ov_seen), 64'd0);

    // Flush in cycle 10 of BUSY
    in_valid = 1'b1; src1 = 64'd1000; src2 = 64'd10; div_control = C_DIVU;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flush_busy.in_ready_low", 64'(in_ready), 64'd0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy.in_ready", 64'(in_ready), 64'd1);
    chk("flush_busy.out_valid", 64'(out_valid), 64'd0);
    ov_seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    chk("flush_busy.no_valid", 64'(ov_seen), 64'd0);

    run_op("divu_9_3", 64'd9, 64'd3, C_DIVU, 64'd3, LAT64, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
